// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B3 arbiter: NUM_MASTERS masters share one slave; ownership held for a whole cyc.
// Grant registered (request in N, grant in N+1); request/response paths are combinational muxes.
// Optional WB_ARB_WATCHDOG_EN: errors out a stalled strobe after TIMEOUT cycles without a slave response.
module wb_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int aw          = 32,
    parameter int dw          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic [NUM_MASTERS*aw-1:0] wbm_adr_i,
    input  logic [NUM_MASTERS*dw-1:0] wbm_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
    output logic [dw-1:0]             wbm_sdt_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [NUM_MASTERS-1:0]    wbm_rty_o,
    output logic [aw-1:0]             wbs_adr_o,
    output logic [dw-1:0]             wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic [dw-1:0]             wbs_sdt_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    input  logic                      wbs_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   owner, owner_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   base;
    logic [IW-1:0]   pick;
    logic            found;
    logic            granted;
    logic            owner_cyc;
    logic            owner_stb;
    logic            slv_resp;
    logic            wd_fire;

    assign granted   = (state == GRANTED);
    assign owner_cyc = wbm_cyc_i[owner];
    assign owner_stb = wbm_stb_i[owner];
    assign slv_resp  = wbs_ack_i | wbs_err_i | wbs_rty_i;

    // Scan starts after the last owner; on release that is the current owner, so it ranks last.
    assign base = granted ? owner : ptr;

    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = int'(base) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && wbm_cyc_i[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANTED;
                    owner_n = pick;
                end
            end
            GRANTED: begin
                if (!owner_cyc) begin
                    ptr_n = owner;
                    if (found) owner_n = pick;
                    else       state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= IW'(NUM_MASTERS - 1);
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
        end
    end

`ifdef WB_ARB_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;

    assign wd_fire = granted && owner_cyc && owner_stb && !slv_resp && (wd_cnt == CW'(TIMEOUT));

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wd_cnt <= '0;
        end else if (!granted || !owner_cyc || slv_resp || wd_fire) begin
            wd_cnt <= '0;
        end else if (owner_stb) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    assign grant_o   = granted ? (NUM_MASTERS'(1) << owner) : '0;

    assign wbs_cyc_o = granted & owner_cyc;
    assign wbs_stb_o = granted & owner_stb & ~wd_fire;
    assign wbs_adr_o = granted ? wbm_adr_i[owner*aw +: aw] : '0;
    assign wbs_dat_o = granted ? wbm_dat_i[owner*dw +: dw] : '0;
    assign wbs_sel_o = granted ? wbm_sel_i[owner*4 +: 4]   : '0;
    assign wbs_cti_o = granted ? wbm_cti_i[owner*3 +: 3]   : '0;
    assign wbs_bte_o = granted ? wbm_bte_i[owner*2 +: 2]   : '0;
    assign wbs_we_o  = granted & wbm_we_i[owner];

    // grant_o is zero when idle, so responses only ever reach the owner.
    assign wbm_sdt_o = wbs_sdt_i;
    assign wbm_ack_o = grant_o & {NUM_MASTERS{wbs_ack_i}};
    assign wbm_err_o = grant_o & {NUM_MASTERS{wbs_err_i | wd_fire}};
    assign wbm_rty_o = grant_o & {NUM_MASTERS{wbs_rty_i}};

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Directed self-checking bench for wb_arbiter_rr (4 masters, TIMEOUT=8).
module tb_wb_arbiter_rr;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] m_adr = '0;
    logic [127:0] m_dat = '0;
    logic [15:0]  m_sel = '0;
    logic [3:0]   m_we  = '0;
    logic [3:0]   m_cyc = '0;
    logic [3:0]   m_stb = '0;
    logic [11:0]  m_cti = '0;
    logic [7:0]   m_bte = '0;
    logic [31:0]  m_sdt;
    logic [3:0]   m_ack, m_err, m_rty;
    logic [31:0]  s_adr, s_dat;
    logic [3:0]   s_sel;
    logic         s_we, s_cyc, s_stb;
    logic [2:0]   s_cti;
    logic [1:0]   s_bte;
    logic [31:0]  s_sdt = '0;
    logic         s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
    logic [3:0]   grant;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    wb_arbiter_rr #(.NUM_MASTERS(4), .aw(32), .dw(32), .TIMEOUT(8)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
        .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
        .wbm_sdt_o(m_sdt), .wbm_ack_o(m_ack), .wbm_err_o(m_err), .wbm_rty_o(m_rty),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
        .wbs_sdt_i(s_sdt), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(grant)
    );

    task automatic set_m(input int m, input logic cyc, input logic stb,
                         input logic [31:0] adr, input logic [2:0] cti);
        m_cyc[m]          = cyc;
        m_stb[m]          = stb;
        m_we[m]           = cyc;
        m_adr[m*32 +: 32] = adr;
        m_dat[m*32 +: 32] = adr ^ 32'h5A5A_0000;
        m_sel[m*4 +: 4]   = 4'hF;
        m_cti[m*3 +: 3]   = cti;
        m_bte[m*2 +: 2]   = 2'b00;
    endtask

    task automatic clear_all();
        for (int m = 0; m < 4; m++) set_m(m, 1'b0, 1'b0, 32'h0, 3'b000);
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_all();
        #1;
        cmp_cnt++; if (grant !== 4'b0000) begin err_cnt++; $display("FAIL reset_grant: got %b want 0000", grant); end
        cmp_cnt++; if ({s_cyc, s_stb} !== 2'b00) begin err_cnt++; $display("FAIL reset_cyc_stb: got %b want 00", {s_cyc, s_stb}); end
        @(negedge clk);
        rst_n = 1'b1;
        set_m(0, 1'b0, 1'b0, 32'hFFFF_0000, 3'b111);
        @(negedge clk);
        cmp_cnt++; if ({s_adr, s_we, s_cti} !== 36'h0) begin err_cnt++; $display("FAIL idle_mux: got adr %h we %b cti %b want zeros", s_adr, s_we, s_cti); end
        clear_all();
    endtask

    task automatic test_single();
        @(negedge clk);
        set_m(2, 1'b1, 1'b1, 32'h100, 3'b000);
        #1;
        cmp_cnt++; if ({grant, s_cyc} !== 5'b0000_0) begin err_cnt++; $display("FAIL single_req_cycle: got grant %b cyc %b want 0000 0", grant, s_cyc); end
        @(negedge clk);
        cmp_cnt++; if (grant !== 4'b0100) begin err_cnt++; $display("FAIL single_grant: got %b want 0100", grant); end
        cmp_cnt++; if ({s_adr, s_dat, s_cyc, s_stb, s_we} !== {32'h100, 32'h5A5A_0100, 3'b111}) begin
            err_cnt++; $display("FAIL single_mux: got adr %h dat %h cyc/stb/we %b", s_adr, s_dat, {s_cyc, s_stb, s_we}); end
        s_ack = 1'b1;
        set_m(2, 1'b0, 1'b0, 32'h100, 3'b000);
        #1;
        cmp_cnt++; if (m_ack !== 4'b0100) begin err_cnt++; $display("FAIL single_ack_on_drop: got %b want 0100", m_ack); end
        @(negedge clk);
        s_ack = 1'b0;
        cmp_cnt++; if (grant !== 4'b0000) begin err_cnt++; $display("FAIL single_release: got %b want 0000", grant); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int m = 0; m < 4; m++) set_m(m, 1'b1, 1'b1, 32'h1000 + 32'(m), 3'b000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp = 4'b0001 << (k % 4);
            cmp_cnt++; if ({grant, s_cyc} !== {exp, 1'b1}) begin
                err_cnt++; $display("FAIL rr_grant_%0d: got %b cyc %b want %b cyc 1", k, grant, s_cyc, exp); end
            for (int m = 0; m < 4; m++) begin
                m_cyc[m] = (m != (k % 4));
                m_stb[m] = (m != (k % 4));
            end
            s_ack = 1'b1;
            #1;
            cmp_cnt++; if (m_ack !== exp) begin err_cnt++; $display("FAIL rr_ack_%0d: got %b want %b", k, m_ack, exp); end
        end
        clear_all();
        @(negedge clk);
    endtask

    task automatic test_burst();
        logic [2:0] cti;
        set_m(1, 1'b1, 1'b1, 32'h200, 3'b010);
        @(negedge clk);
        cmp_cnt++; if (grant !== 4'b0010) begin err_cnt++; $display("FAIL burst_grant: got %b want 0010", grant); end
        set_m(0, 1'b1, 1'b1, 32'h300, 3'b000);
        s_ack = 1'b1;
        for (int b = 0; b < 4; b++) begin
            cti = (b == 3) ? 3'b111 : 3'b010;
            set_m(1, 1'b1, 1'b1, 32'h200 + 32'(4 * b), cti);
            #1;
            cmp_cnt++; if ({grant, s_adr, s_cti, s_bte} !== {4'b0010, 32'h200 + 32'(4 * b), cti, 2'b00}) begin
                err_cnt++; $display("FAIL burst_beat_%0d: got grant %b adr %h cti %b bte %b", b, grant, s_adr, s_cti, s_bte); end
            @(negedge clk);
        end
        s_ack = 1'b0;
        set_m(1, 1'b1, 1'b0, 32'h20C, 3'b111);
        @(negedge clk);
        cmp_cnt++; if (grant !== 4'b0010) begin err_cnt++; $display("FAIL burst_hold_after_eob: got %b want 0010", grant); end
        set_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
        @(negedge clk);
        cmp_cnt++; if ({grant, s_adr} !== {4'b0001, 32'h300}) begin
            err_cnt++; $display("FAIL burst_handover: got grant %b adr %h want 0001 300", grant, s_adr); end
        clear_all();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        set_m(3, 1'b1, 1'b1, 32'h500, 3'b010);
        @(negedge clk);
        cmp_cnt++; if ({grant, s_cyc, s_stb} !== 6'b1000_11) begin
            err_cnt++; $display("FAIL rst_burst_grant: got grant %b cyc/stb %b want 1000 11", grant, {s_cyc, s_stb}); end
        #2 rst_n = 1'b0;
        #1;
        cmp_cnt++; if ({grant, s_cyc, s_stb} !== 6'b0000_00) begin
            err_cnt++; $display("FAIL rst_async_drop: got grant %b cyc/stb %b want 0000 00", grant, {s_cyc, s_stb}); end
        @(negedge clk);
        rst_n = 1'b1;
        set_m(0, 1'b1, 1'b1, 32'h600, 3'b000);
        @(negedge clk);
        cmp_cnt++; if (grant !== 4'b0001) begin err_cnt++; $display("FAIL rst_then_first: got %b want 0001", grant); end
        clear_all();
        @(negedge clk);
    endtask

    task automatic test_non_owner();
        set_m(1, 1'b1, 1'b1, 32'h400, 3'b000);
        @(negedge clk);
        cmp_cnt++; if (grant !== 4'b0010) begin err_cnt++; $display("FAIL nonown_grant: got %b want 0010", grant); end
        set_m(0, 1'b1, 1'b1, 32'h700, 3'b000);
        s_ack = 1'b1; s_sdt = 32'hCAFE_0001;
        #1;
        cmp_cnt++; if ({m_ack, m_sdt, s_adr} !== {4'b0010, 32'hCAFE_0001, 32'h400}) begin
            err_cnt++; $display("FAIL nonown_ack: got ack %b sdt %h adr %h want 0010 cafe0001 400", m_ack, m_sdt, s_adr); end
        s_ack = 1'b0; s_err = 1'b1; s_sdt = 32'h1234_5678;
        #1;
        cmp_cnt++; if ({m_err, m_ack, m_sdt} !== {4'b0010, 4'b0000, 32'h1234_5678}) begin
            err_cnt++; $display("FAIL nonown_err: got err %b ack %b sdt %h want 0010 0000 12345678", m_err, m_ack, m_sdt); end
        s_err = 1'b0; s_rty = 1'b1;
        #1;
        cmp_cnt++; if ({m_rty, m_err} !== 8'b0010_0000) begin
            err_cnt++; $display("FAIL nonown_rty: got rty %b err %b want 0010 0000", m_rty, m_err); end
        clear_all();
        @(negedge clk);
    endtask

    task automatic test_hung_slave();
        int first_stb = -1;
        int err_cyc   = -1;
        int errs      = 0;
        int stbs      = 0;
        logic stb_at_err = 1'b1;
        set_m(2, 1'b1, 1'b1, 32'h800, 3'b000);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_stb) stbs++;
            if (s_stb && first_stb < 0) first_stb = c;
            if (m_err !== 4'b0000) begin
                errs++;
                if (err_cyc < 0) begin err_cyc = c; stb_at_err = s_stb; end
                set_m(2, 1'b0, 1'b0, 32'h0, 3'b000);
            end
        end
`ifdef WB_ARB_WATCHDOG_EN
        cmp_cnt++; if (errs !== 1) begin err_cnt++; $display("FAIL wd_pulse_count: got %0d want 1", errs); end
        cmp_cnt++; if (err_cyc - first_stb !== 8) begin err_cnt++; $display("FAIL wd_latency: got %0d want 8", err_cyc - first_stb); end
        cmp_cnt++; if (stb_at_err !== 1'b0) begin err_cnt++; $display("FAIL wd_stb_forced: got %b want 0", stb_at_err); end
`else
        cmp_cnt++; if (errs !== 0) begin err_cnt++; $display("FAIL hang_no_err: got %0d err cycles want 0", errs); end
        cmp_cnt++; if (stbs !== 20) begin err_cnt++; $display("FAIL hang_stb_held: got %0d stb cycles want 20", stbs); end
`endif
        clear_all();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_reset_mid_burst();
        test_non_owner();
        test_hung_slave();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
